// File: rtl/synth_pkg.sv
// Shared types and helpers for the polyphonic mixer datapath.
package synth_pkg;

  // Wide enough for the largest shift (log2 of 32 voices).
  localparam int unsigned SHIFT_W = 3;

  typedef enum logic [1:0] {
    MIX_FIXED = 2'b00,
    MIX_SAT   = 2'b01,
    MIX_AUTO  = 2'b10
  } mix_mode_e;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    SCALE,
    OUT
  } mixer_state_e;

  // ceil(log2(max(count,1))) for counts up to 32.
  function automatic logic [SHIFT_W-1:0] clog2_shift(input logic [5:0] count);
    logic [SHIFT_W-1:0] s;
    s = '0;
    for (int i = 0; i < 6; i++) begin
      if ((6'd1 << i) < count) s = SHIFT_W'(i + 1);
    end
    return s;
  endfunction

  function automatic logic signed [63:0] sat_to_width(input logic signed [63:0] val,
                                                      input int unsigned width);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (width - 1));
    if (val > hi) return hi;
    if (val < lo) return lo;
    return val;
  endfunction

endpackage

// File: rtl/mix_gain_sat.sv
// Headroom shift, master gain and saturation; result and clip flag are registered on i_load.
module mix_gain_sat #(
  parameter int unsigned ACC_W    = 20,
  parameter int unsigned SAMPLE_W = 16,
  parameter int unsigned GAIN_W   = 8
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic                        i_load,
  input  logic [ACC_W-1:0]            i_acc,
  input  logic [synth_pkg::SHIFT_W-1:0] i_shift,
  input  logic [GAIN_W-1:0]           i_gain,
  output logic [SAMPLE_W-1:0]         o_sample,
  output logic                        o_sat
);
  import synth_pkg::*;

  localparam int unsigned PROD_W = ACC_W + GAIN_W + 1;

  logic signed [ACC_W-1:0]  w_s;
  logic signed [PROD_W-1:0] w_s_ext;
  logic signed [PROD_W-1:0] w_g_ext;
  logic signed [PROD_W-1:0] w_prod;
  logic signed [PROD_W-1:0] w_p;
  logic signed [63:0]       w_p64;
  logic signed [63:0]       w_sat64;
  logic [SAMPLE_W-1:0]      r_sample;
  logic                     r_sat;

  assign w_s     = $signed(i_acc) >>> i_shift;
  assign w_s_ext = $signed({{(GAIN_W + 1){w_s[ACC_W-1]}}, w_s});
  // Gain is unsigned: the extra zero bit keeps it positive in the signed product.
  assign w_g_ext = $signed({{(ACC_W + 1){1'b0}}, i_gain});
  assign w_prod  = w_s_ext * w_g_ext;
  assign w_p     = w_prod >>> GAIN_W;
  assign w_p64   = $signed({{(64 - PROD_W){w_p[PROD_W-1]}}, w_p});
  assign w_sat64 = sat_to_width(w_p64, SAMPLE_W);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sample <= '0;
      r_sat    <= 1'b0;
    end else if (i_load) begin
      r_sample <= w_sat64[SAMPLE_W-1:0];
      r_sat    <= (w_sat64 != w_p64);
    end
  end

  assign o_sample = r_sample;
  assign o_sat    = r_sat;

endmodule

// File: rtl/poly_mixer.sv
// N-voice sequential mixer: snapshot on sample_req, accumulate one voice per cycle,
// then scale, apply master gain and saturate.
module poly_mixer #(
  parameter int unsigned NUM_VOICES = 8,
  parameter int unsigned SAMPLE_W   = 16,
  parameter int unsigned GAIN_W     = 8
) (
  input  logic                           Clk,
  input  logic                           Reset,
  input  logic                           sample_req,
  input  logic [NUM_VOICES*SAMPLE_W-1:0] voice_in,
  input  logic [NUM_VOICES-1:0]          voice_en,
  input  logic [1:0]                     mode,
  input  logic [GAIN_W-1:0]              master_gain,
  input  logic                           clr_flags,
  output logic [SAMPLE_W-1:0]            mix_out,
  output logic                           out_valid,
  output logic                           busy,
  output logic                           clip,
  output logic                           overrun
);
  import synth_pkg::*;

  localparam int unsigned IDX_W = $clog2(NUM_VOICES);
  localparam int unsigned CNT_W = IDX_W + 1;
  localparam int unsigned ACC_W = SAMPLE_W + IDX_W + 1;

  mixer_state_e            r_state;
  mixer_state_e            w_state_next;
  logic [SAMPLE_W-1:0]     r_voice [NUM_VOICES];
  logic [NUM_VOICES-1:0]   r_en;
  logic [1:0]              r_mode;
  logic [GAIN_W-1:0]       r_gain;
  logic signed [ACC_W-1:0] r_acc;
  logic [CNT_W-1:0]        r_active;
  logic [IDX_W-1:0]        r_idx;
  logic                    r_clip;
  logic                    r_overrun;
  logic [SAMPLE_W-1:0]     w_voice;
  logic signed [ACC_W-1:0] w_voice_ext;
  logic [SHIFT_W-1:0]      w_shift;
  logic                    w_sat;

  assign w_voice     = r_voice[r_idx];
  assign w_voice_ext = {{(ACC_W - SAMPLE_W){w_voice[SAMPLE_W-1]}}, w_voice};

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      IDLE:  if (sample_req) w_state_next = ACCUM;
      ACCUM: if (r_idx == IDX_W'(NUM_VOICES - 1)) w_state_next = SCALE;
      SCALE: w_state_next = OUT;
      OUT:   w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int k = 0; k < NUM_VOICES; k++) r_voice[k] <= '0;
      r_en     <= '0;
      r_mode   <= '0;
      r_gain   <= '0;
      r_acc    <= '0;
      r_active <= '0;
      r_idx    <= '0;
    end else begin
      if (r_state == IDLE && sample_req) begin
        for (int k = 0; k < NUM_VOICES; k++) r_voice[k] <= voice_in[k*SAMPLE_W +: SAMPLE_W];
        r_en     <= voice_en;
        r_mode   <= mode;
        r_gain   <= master_gain;
        r_acc    <= '0;
        r_active <= '0;
        r_idx    <= '0;
      end else if (r_state == ACCUM) begin
        if (r_en[r_idx]) begin
          r_acc    <= r_acc + w_voice_ext;
          r_active <= r_active + CNT_W'(1);
        end
        r_idx <= r_idx + IDX_W'(1);
      end
    end
  end

  // Mode 2'b11 falls through to the fixed shift.
  always_comb begin
    w_shift = SHIFT_W'(IDX_W);
    if (r_mode == MIX_SAT)       w_shift = '0;
    else if (r_mode == MIX_AUTO) w_shift = clog2_shift(6'(r_active));
  end

  mix_gain_sat #(
    .ACC_W    (ACC_W),
    .SAMPLE_W (SAMPLE_W),
    .GAIN_W   (GAIN_W)
  ) u_gain_sat (
    .i_clk    (Clk),
    .i_rst    (Reset),
    .i_load   (r_state == SCALE),
    .i_acc    (r_acc),
    .i_shift  (w_shift),
    .i_gain   (r_gain),
    .o_sample (mix_out),
    .o_sat    (w_sat)
  );

  // Sticky flags: a set in the same cycle wins over clr_flags.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_clip    <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      if (r_state == OUT && w_sat) r_clip <= 1'b1;
      else if (clr_flags)          r_clip <= 1'b0;
      if (sample_req && r_state != IDLE) r_overrun <= 1'b1;
      else if (clr_flags)                r_overrun <= 1'b0;
    end
  end

  assign out_valid = (r_state == OUT);
  assign busy      = (r_state == ACCUM) || (r_state == SCALE);
  assign clip      = r_clip;
  assign overrun   = r_overrun;

endmodule
